pkt_prio_fifo: RTL and testbench

Multi-queue packet FIFO with store-and-forward commit, for the SRAM controller ingress path. It sorts incoming sop/eop-framed packets into NUM_PRI per-priority queues. A packet becomes readable only after its eop beat is written. The read side serves whole packets under strict priority, and a packet that would overflow its queue is dropped whole rather than truncated.

---
 rtl/pkt_prio_fifo.sv | 221 ++++++++++++++++++++++
 tb/tb_pkt_prio_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_prio_fifo.sv
// pkt_prio_fifo: multi-queue packet FIFO with store-and-forward commit.
// Beats are sorted into NUM_PRI queues by the priority carried on the sop beat;
// a packet becomes visible to the reader only once its eop beat is stored, and
// the reader drains whole packets under strict priority (highest index wins).
// Read handshake: rd_vld high means rd_sop/rd_eop/rd_pri/rd_data show the head
// beat of the selected packet; that beat is consumed on a rising clk edge where
// rd_vld && rd_en. rd_en while rd_vld is low has no effect. The write side has
// no backpressure: every wr_vld beat is either stored or discarded.
module pkt_prio_fifo #(
    parameter int DATA_W  = 16,
    parameter int NUM_PRI = 8,
    parameter int DEPTH   = 32,
    parameter int PRI_W   = $clog2(NUM_PRI)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_vld,
    input  logic               wr_sop,
    input  logic               wr_eop,
    input  logic [PRI_W-1:0]   wr_pri,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               rd_en,
    output logic               rd_vld,
    output logic               rd_sop,
    output logic               rd_eop,
    output logic [PRI_W-1:0]   rd_pri,
    output logic [DATA_W-1:0]  rd_data,
    output logic [NUM_PRI-1:0] pkt_avail,
    output logic [NUM_PRI-1:0] overflow,
    output logic               drop
);
    localparam int AW    = $clog2(DEPTH);
    localparam int MA    = PRI_W + AW;
    localparam int MW    = DATA_W + 2;
    localparam int MEM_N = 2 ** MA;
    localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_PKT  = 2'd1;
    localparam logic [1:0] WR_DROP = 2'd2;
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_PKT  = 1'b1;

    // Entry layout {sop, eop, data}; queue q owns addresses {q, ptr[AW-1:0]}.
    logic [MW-1:0] mem [MEM_N];

    logic [AW:0]        rptr_q [NUM_PRI];
    logic [AW:0]        rptr_d [NUM_PRI];
    logic [AW:0]        tptr_q [NUM_PRI];
    logic [AW:0]        tptr_d [NUM_PRI];
    logic [AW:0]        cptr_q [NUM_PRI];
    logic [AW:0]        cptr_d [NUM_PRI];
    logic [AW:0]        cnt_q  [NUM_PRI];
    logic [AW:0]        cnt_d  [NUM_PRI];
    logic [1:0]         wr_st_q, wr_st_d;
    logic [PRI_W-1:0]   cur_q_q, cur_q_d;
    logic [0:0]         rd_st_q, rd_st_d;
    logic [PRI_W-1:0]   sel_q_q, sel_q_d;
    logic [NUM_PRI-1:0] ovf_q, ovf_d;
    logic               drop_q, drop_d;

    logic               mem_we;
    logic [MA-1:0]      mem_waddr;
    logic [MW-1:0]      mem_wdata;
    logic               take;
    logic [PRI_W-1:0]   beat_q;
    logic [AW:0]        beat_ptr;
    logic               commit;
    logic [PRI_W-1:0]   commit_pri;
    logic               pop_eop;
    logic [PRI_W-1:0]   top_pri;
    logic [MW-1:0]      rd_word;

    // Write FSM: place each accepted beat at the tentative pointer, commit on
    // eop, rewind the queue on overflow or on an abort by a fresh sop.
    always_comb begin
        wr_st_d    = wr_st_q;
        cur_q_d    = cur_q_q;
        ovf_d      = ovf_q;
        drop_d     = 1'b0;
        for (int q = 0; q < NUM_PRI; q++) begin
            tptr_d[q] = tptr_q[q];
            cptr_d[q] = cptr_q[q];
        end
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = {wr_sop, wr_eop, wr_data};
        commit     = 1'b0;
        commit_pri = cur_q_q;
        take       = 1'b0;
        beat_q     = cur_q_q;
        beat_ptr   = tptr_q[cur_q_q];
        if (wr_vld) begin
            if (wr_sop) begin
                // A sop outside WR_IDLE abandons the partial packet first; the
                // new packet then starts from the rewound pointer of its queue.
                if (wr_st_q != WR_IDLE) begin
                    tptr_d[cur_q_q] = cptr_q[cur_q_q];
                end
                if (wr_st_q == WR_PKT) begin
                    drop_d = 1'b1;
                end
                take     = 1'b1;
                beat_q   = wr_pri;
                beat_ptr = (wr_st_q != WR_IDLE && wr_pri == cur_q_q) ?
                           cptr_q[wr_pri] : tptr_q[wr_pri];
                cur_q_d  = wr_pri;
            end else if (wr_st_q == WR_PKT) begin
                take = 1'b1;
            end else if (wr_st_q == WR_DROP && wr_eop) begin
                wr_st_d = WR_IDLE;
            end
        end
        if (take) begin
            if ((beat_ptr - rptr_q[beat_q]) == FULL_LVL) begin
                tptr_d[beat_q] = cptr_q[beat_q];
                ovf_d[beat_q]  = 1'b1;
                drop_d         = 1'b1;
                wr_st_d        = wr_eop ? WR_IDLE : WR_DROP;
            end else begin
                mem_we         = 1'b1;
                mem_waddr      = {beat_q, beat_ptr[AW-1:0]};
                tptr_d[beat_q] = beat_ptr + PTR_ONE;
                if (wr_eop) begin
                    cptr_d[beat_q] = beat_ptr + PTR_ONE;
                    commit         = 1'b1;
                    commit_pri     = beat_q;
                    wr_st_d        = WR_IDLE;
                end else begin
                    wr_st_d = WR_PKT;
                end
            end
        end
    end

    // Strict-priority pick among queues holding committed packets.
    always_comb begin
        top_pri = '0;
        for (int q = 0; q < NUM_PRI; q++) begin
            if (pkt_avail[q]) top_pri = PRI_W'(q);
        end
    end

    assign rd_word = mem[{sel_q_q, rptr_q[sel_q_q][AW-1:0]}];

    // Read FSM: lock onto one queue for a whole packet, pop on rd_en.
    always_comb begin
        rd_st_d = rd_st_q;
        sel_q_d = sel_q_q;
        pop_eop = 1'b0;
        for (int q = 0; q < NUM_PRI; q++) rptr_d[q] = rptr_q[q];
        if (rd_st_q == RD_IDLE) begin
            if (|pkt_avail) begin
                sel_q_d = top_pri;
                rd_st_d = RD_PKT;
            end
        end else if (rd_en) begin
            rptr_d[sel_q_q] = rptr_q[sel_q_q] + PTR_ONE;
            if (rd_word[MW-2]) begin
                pop_eop = 1'b1;
                rd_st_d = RD_IDLE;
            end
        end
    end

    // Committed-packet counters: +1 on commit, -1 when a packet's eop is popped.
    always_comb begin
        for (int q = 0; q < NUM_PRI; q++) begin
            cnt_d[q] = cnt_q[q];
            if (commit && commit_pri == PRI_W'(q)) cnt_d[q] = cnt_d[q] + PTR_ONE;
            if (pop_eop && sel_q_q == PRI_W'(q))   cnt_d[q] = cnt_d[q] - PTR_ONE;
            pkt_avail[q] = (cnt_q[q] != '0);
        end
    end

    // State and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int q = 0; q < NUM_PRI; q++) begin
                rptr_q[q] <= '0;
                tptr_q[q] <= '0;
                cptr_q[q] <= '0;
                cnt_q[q]  <= '0;
            end
            wr_st_q <= WR_IDLE;
            cur_q_q <= '0;
            rd_st_q <= RD_IDLE;
            sel_q_q <= '0;
            ovf_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            for (int q = 0; q < NUM_PRI; q++) begin
                rptr_q[q] <= rptr_d[q];
                tptr_q[q] <= tptr_d[q];
                cptr_q[q] <= cptr_d[q];
                cnt_q[q]  <= cnt_d[q];
            end
            wr_st_q <= wr_st_d;
            cur_q_q <= cur_q_d;
            rd_st_q <= rd_st_d;
            sel_q_q <= sel_q_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Packet storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign rd_vld    = (rd_st_q == RD_PKT);
    assign rd_sop    = rd_vld & rd_word[MW-1];
    assign rd_eop    = rd_vld & rd_word[MW-2];
    assign rd_pri    = rd_vld ? sel_q_q : '0;
    assign rd_data   = rd_vld ? rd_word[DATA_W-1:0] : '0;
    assign overflow  = ovf_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_pkt_prio_fifo.sv
// tb_pkt_prio_fifo: randomized bench for pkt_prio_fifo with a packet-level
// reference model (per-queue beat lists, packet counts) and a scoreboard.
module tb_pkt_prio_fifo;
  localparam int DATA_W  = 16;
  localparam int NUM_PRI = 8;
  localparam int DEPTH   = 32;
  localparam int PRI_W   = 3;
  localparam int BW      = DATA_W + 2;
  localparam int EW      = PRI_W + BW;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  logic wr_vld, wr_sop, wr_eop;
  logic [PRI_W-1:0] wr_pri;
  logic [DATA_W-1:0] wr_data;
  logic rd_en;
  logic rd_vld, rd_sop, rd_eop;
  logic [PRI_W-1:0] rd_pri;
  logic [DATA_W-1:0] rd_data;
  logic [NUM_PRI-1:0] pkt_avail, overflow;
  logic drop;

  always #5 clk = ~clk;

  pkt_prio_fifo #(.DATA_W(DATA_W), .NUM_PRI(NUM_PRI), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_vld(wr_vld), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_pri(wr_pri), .wr_data(wr_data),
    .rd_en(rd_en), .rd_vld(rd_vld), .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_pri(rd_pri),
    .rd_data(rd_data), .pkt_avail(pkt_avail), .overflow(overflow), .drop(drop)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [BW-1:0] qbeats [NUM_PRI][$];
  int            pcnt [NUM_PRI];
  logic [BW-1:0] cur_buf [$];
  int            cur_pri = 0;
  bit            in_pkt = 0;
  bit            m_busy = 0;
  int            m_sel = 0;
  logic [EW-1:0] exp_q [$];
  logic          exp_vld = 1'b0;
  logic          exp_drop = 1'b0;
  logic [NUM_PRI-1:0] exp_avail = '0;
  logic [NUM_PRI-1:0] exp_ovf = '0;
  bit            model_live = 0;
  bit            post_rst = 0;

  always @(posedge clk) begin
    bit pend;
    int pend_pri;
    bit take;
    logic [BW-1:0] b;
    pend = 0;
    pend_pri = 0;
    take = 0;
    if (rst) begin
      for (int q = 0; q < NUM_PRI; q++) begin
        qbeats[q].delete();
        pcnt[q] = 0;
      end
      cur_buf.delete();
      in_pkt = 0;
      m_busy = 0;
      exp_q.delete();
      exp_vld = 0;
      exp_drop = 0;
      exp_avail = '0;
      exp_ovf = '0;
      model_live = 1;
      post_rst = 1;
    end else begin
      post_rst = 0;
      exp_drop = 0;
      // write side: occupancy seen here excludes pops made at this same edge
      if (wr_vld) begin
        if (wr_sop) begin
          if (in_pkt) exp_drop = 1;
          cur_buf.delete();
          in_pkt = 0;
          cur_pri = int'(wr_pri);
          take = 1;
        end else if (in_pkt) begin
          take = 1;
        end
        if (take) begin
          if (qbeats[cur_pri].size() + cur_buf.size() >= DEPTH) begin
            exp_ovf[cur_pri] = 1'b1;
            exp_drop = 1;
            cur_buf.delete();
            in_pkt = 0;
          end else begin
            cur_buf.push_back({wr_sop, wr_eop, wr_data});
            if (wr_eop) begin
              pend = 1;
              pend_pri = cur_pri;
              in_pkt = 0;
            end else begin
              in_pkt = 1;
            end
          end
        end
      end
      // read side: packets committed at this edge are not yet selectable
      if (m_busy) begin
        if (rd_en) begin
          b = qbeats[m_sel].pop_front();
          if (b[BW-2]) begin
            m_busy = 0;
            pcnt[m_sel]--;
          end
        end
      end else begin
        for (int q = NUM_PRI - 1; q >= 0; q--) begin
          if (!m_busy && pcnt[q] > 0) begin
            m_sel = q;
            m_busy = 1;
          end
        end
        if (m_busy) begin
          for (int i = 0; i < qbeats[m_sel].size(); i++) begin
            b = qbeats[m_sel][i];
            exp_q.push_back({PRI_W'(m_sel), b});
            if (b[BW-2]) break;
          end
        end
      end
      if (pend) begin
        while (cur_buf.size() > 0) qbeats[pend_pri].push_back(cur_buf.pop_front());
        pcnt[pend_pri]++;
      end
      exp_vld = m_busy;
      for (int q = 0; q < NUM_PRI; q++) exp_avail[q] = (pcnt[q] > 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (model_live) begin
      check("rd_vld", 64'(rd_vld), 64'(exp_vld));
      check("pkt_avail", 64'(pkt_avail), 64'(exp_avail));
      check("overflow", 64'(overflow), 64'(exp_ovf));
      check("drop", 64'(drop), 64'(exp_drop));
      if (post_rst) check("reset_outputs", 64'({rd_sop, rd_eop, rd_pri, rd_data}), 64'(0));
      if (rd_vld) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'({rd_pri, rd_sop, rd_eop, rd_data}), 64'(0));
        end else begin
          check("beat", 64'({rd_pri, rd_sop, rd_eop, rd_data}), 64'(exp_q[0]));
          if (rd_en) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- drivers ----------------
  int rd_pct = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rd_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rd_en = ($urandom_range(0, 99) < rd_pct);
    end
  end

  task automatic beat(input bit s, input bit e, input int p, input logic [DATA_W-1:0] d);
    wr_vld = 1'b1;
    wr_sop = s;
    wr_eop = e;
    wr_pri = PRI_W'(p);
    wr_data = d;
    tick();
    wr_vld = 1'b0;
    wr_sop = 1'b0;
    wr_eop = 1'b0;
    wr_pri = PRI_W'($urandom_range(0, NUM_PRI - 1));
  endtask

  // Non-sop beats carry a random priority: only the sop beat's value counts.
  task automatic send_pkt(input int p, input int len, input int gap_max);
    for (int i = 0; i < len; i++) begin
      beat(i == 0, i == len - 1, (i == 0) ? p : int'($urandom_range(0, NUM_PRI - 1)),
           DATA_W'($urandom));
      repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  function automatic int model_pkts();
    int s = 0;
    for (int q = 0; q < NUM_PRI; q++) s += pcnt[q];
    return s;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    rd_pct = 100;
    while ((m_busy || model_pkts() > 0) && n < budget) begin
      tick();
      n++;
    end
    tick();
    check("drain_done", 64'(model_pkts()), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    wr_vld = 1'b0;
    wr_sop = 1'b0;
    wr_eop = 1'b0;
    wr_pri = '0;
    wr_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // single packet, fixed data, read after commit
    rd_pct = 0;
    beat(1, 0, 2, 16'h0011);
    beat(0, 0, 5, 16'h0022);
    beat(0, 1, 1, 16'h0033);
    repeat (3) tick();
    drain(200);

    // strict priority among committed packets
    rd_pct = 0;
    send_pkt(1, 2, 0);
    send_pkt(6, 1, 0);
    tick();
    drain(200);

    // no preemption of a packet already being read
    rd_pct = 0;
    send_pkt(5, 6, 0);
    tick();
    rd_pct = 50;
    repeat (2) tick();
    send_pkt(3, 2, 0);
    drain(200);

    // overflow: 30-beat packet fills all but two slots, next 4-beat packet drops
    rd_pct = 0;
    send_pkt(0, 30, 0);
    send_pkt(0, 4, 0);
    repeat (2) tick();
    drain(400);

    // abort by a new sop mid-packet
    rd_pct = 0;
    beat(1, 0, 7, 16'h0aaa);
    beat(0, 0, 7, 16'h0bbb);
    beat(1, 0, 4, 16'h0ccc);
    beat(0, 1, 4, 16'h0ddd);
    tick();
    drain(200);

    // reset while a packet is being written and another is being read
    rd_pct = 0;
    send_pkt(2, 5, 0);
    rd_pct = 100;
    beat(1, 0, 3, 16'h1234);
    beat(0, 0, 3, 16'h5678);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    rd_pct = 0;
    send_pkt(6, 3, 1);
    drain(200);

    // randomized traffic with aborts, stray beats and varying read pressure
    for (int k = 0; k < 250; k++) begin
      if (k % 40 == 0) begin
        case ($urandom_range(0, 3))
          0: rd_pct = 0;
          1: rd_pct = 30;
          2: rd_pct = 70;
          default: rd_pct = 100;
        endcase
      end
      if ($urandom_range(0, 11) == 0) beat(0, $urandom_range(0, 1), 0, DATA_W'($urandom));
      if ($urandom_range(0, 14) == 0) begin
        send_pkt($urandom_range(0, NUM_PRI - 1), 1, 0);
        beat(1, 0, $urandom_range(0, NUM_PRI - 1), DATA_W'($urandom));
        beat(0, 0, 0, DATA_W'($urandom));
      end
      send_pkt($urandom_range(0, NUM_PRI - 1), $urandom_range(1, 10), $urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) tick();
    end
    drain(3000);
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
